// File: rtl/tunnel_carver_pkg.sv
// Shared definitions for the tunnel carver: geometry, tile codes, FSM encoding
// and the initial-level fill pattern.
package tunnel_carver_pkg;

   localparam int TILE_PX  = 40;  // tile edge in pixels
   localparam int MAP_COLS = 16;  // tiles per row
   localparam int MAP_ROWS = 15;  // valid rows, addresses 240..255 unused
   localparam int RD_LAT   = 1;   // RAM read latency in clk100m cycles

   localparam logic [3:0] TILE_TUNNEL  = 4'd0;
   localparam logic [3:0] TILE_DIRT    = 4'd1;
   localparam logic [3:0] TILE_EMERALD = 4'd2;
   localparam logic [3:0] TILE_BAG     = 4'd3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FILL,
      ST_DIV,
      ST_RD,
      ST_WAIT,
      ST_EVAL,
      ST_WR
   } state_t;

   // Initial level: open top row and unused tail, emeralds every 8th tile, dirt elsewhere.
   function automatic logic [3:0] fill_code(input logic [7:0] addr);
      if (addr[7:4] >= 4'(MAP_ROWS) || addr[7:4] == 4'd0) return TILE_TUNNEL;
      if (addr[2:0] == 3'b101)                            return TILE_EMERALD;
      return TILE_DIRT;
   endfunction

endpackage

// File: rtl/px_to_tile.sv
// Iterative pixel -> tile divider. One subtraction of TILE_PX per coordinate
// per cycle, both coordinates in parallel; results clamp to the play field.
module px_to_tile
   import tunnel_carver_pkg::*;
(
   input  logic       clk100m,
   input  logic       rst_n,
   input  logic       start,
   input  logic [9:0] posx,
   input  logic [9:0] posy,
   output logic       done,
   output logic [3:0] col,
   output logic [3:0] row
);

   localparam logic [9:0] STEP    = 10'(TILE_PX);
   localparam logic [4:0] COL_MAX = 5'(MAP_COLS - 1);
   localparam logic [4:0] ROW_MAX = 5'(MAP_ROWS - 1);

   logic [9:0] rem_x, rem_y;
   logic [4:0] quo_x, quo_y;
   logic       running;
   logic       step_x, step_y;

   assign step_x = (rem_x >= STEP);
   assign step_y = (rem_y >= STEP);
   assign done   = running && !step_x && !step_y;
   assign col    = (quo_x > COL_MAX) ? COL_MAX[3:0] : quo_x[3:0];
   assign row    = (quo_y > ROW_MAX) ? ROW_MAX[3:0] : quo_y[3:0];

   // Load the captured position on start, then subtract until both remainders are below a tile.
   always_ff @(posedge clk100m or negedge rst_n) begin
      if (!rst_n) begin
         rem_x   <= '0;
         rem_y   <= '0;
         quo_x   <= '0;
         quo_y   <= '0;
         running <= 1'b0;
      end else if (start) begin
         rem_x   <= posx;
         rem_y   <= posy;
         quo_x   <= '0;
         quo_y   <= '0;
         running <= 1'b1;
      end else if (running) begin
         // NOTE: non-blocking assignments keep every register update on the same edge, independent of statement order.
         if (step_x) begin
            rem_x <= rem_x - STEP;
            quo_x <= quo_x + 5'd1;
         end
         if (step_y) begin
            rem_y <= rem_y - STEP;
            quo_y <= quo_y + 5'd1;
         end
         if (!step_x && !step_y) running <= 1'b0;
      end
   end

endmodule

// File: rtl/tunnel_carver.sv
// Write side of the 256x4 tile map RAM: fills the initial level on level_start,
// then carves dirt/emerald into tunnel as the digger enters new tiles.
module tunnel_carver
   import tunnel_carver_pkg::*;
(
   input  logic       clk100m,
   input  logic       rst_n,
   input  logic       level_start,
   input  logic [9:0] dig_posx,
   input  logic [9:0] dig_posy,
   input  logic [3:0] vgaram_douta,
   output logic       vgaram_we,
   output logic [7:0] vgaram_addra,
   output logic [3:0] vgaram_dina,
   output logic       score_inc,
   output logic       busy
);

   localparam logic [3:0] WAIT_LAST = 4'(RD_LAT - 2);

   state_t     state, state_d;
   logic [7:0] fill_cnt, fill_cnt_d;
   logic [7:0] tile, last_tile;
   logic [3:0] wait_cnt;

   logic       we_d, score_d;
   logic [7:0] addr_d;
   logic [3:0] dina_d;

   logic       div_done;
   logic [3:0] div_col, div_row;
   logic [7:0] div_tile;

   px_to_tile u_div (
      .clk100m (clk100m),
      .rst_n   (rst_n),
      .start   (state == ST_IDLE),
      .posx    (dig_posx),
      .posy    (dig_posy),
      .done    (div_done),
      .col     (div_col),
      .row     (div_row)
   );

   // row*MAP_COLS + col with MAP_COLS = 16 is a plain concatenation.
   assign div_tile = {div_row, div_col};
   assign busy     = (state != ST_IDLE);

   // State register.
   always_ff @(posedge clk100m or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_d;
   end

   // Next-state logic; level_start pre-empts everything and (re)starts the fill.
   always_comb begin
      // NOTE: defaults first so every path assigns every output and no latch is inferred.
      state_d    = state;
      fill_cnt_d = fill_cnt;
      if (level_start) begin
         state_d    = ST_FILL;
         fill_cnt_d = 8'd0;
      end else begin
         case (state)
            ST_IDLE: state_d = ST_DIV;
            ST_FILL: begin
               if (fill_cnt == 8'hFF) state_d = ST_IDLE;
               else                   fill_cnt_d = fill_cnt + 8'd1;
            end
            ST_DIV: begin
               if (div_done) state_d = (div_tile == last_tile) ? ST_IDLE : ST_RD;
            end
            ST_RD:   state_d = (RD_LAT > 1) ? ST_WAIT : ST_EVAL;
            ST_WAIT: if (wait_cnt == WAIT_LAST) state_d = ST_EVAL;
            ST_EVAL: begin
               if (vgaram_douta == TILE_DIRT || vgaram_douta == TILE_EMERALD) state_d = ST_WR;
               else                                                           state_d = ST_IDLE;
            end
            ST_WR:   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Output values for the coming state, registered below so they line up with it.
   always_comb begin
      we_d    = (state_d == ST_FILL) || (state_d == ST_WR);
      addr_d  = vgaram_addra;
      dina_d  = vgaram_dina;
      score_d = 1'b0;
      case (state_d)
         ST_FILL: begin
            addr_d = fill_cnt_d;
            dina_d = fill_code(fill_cnt_d);
         end
         ST_RD:   addr_d = div_tile;
         ST_WR: begin
            addr_d  = tile;
            dina_d  = TILE_TUNNEL;
            score_d = (vgaram_douta == TILE_EMERALD);
         end
         default: ;
      endcase
   end

   // Datapath registers: RAM port, fill index, tile tracking, read-latency counter.
   always_ff @(posedge clk100m or negedge rst_n) begin
      if (!rst_n) begin
         vgaram_we    <= 1'b0;
         vgaram_addra <= '0;
         vgaram_dina  <= '0;
         score_inc    <= 1'b0;
         fill_cnt     <= '0;
         tile         <= '0;
         last_tile    <= 8'hFF;
         wait_cnt     <= '0;
      end else begin
         vgaram_we    <= we_d;
         vgaram_addra <= addr_d;
         vgaram_dina  <= dina_d;
         score_inc    <= score_d;
         fill_cnt     <= fill_cnt_d;
         if (state == ST_DIV && div_done) tile <= div_tile;
         // 8'hFF never matches a real tile, so the first position after a fill is always evaluated.
         if (state_d == ST_FILL)      last_tile <= 8'hFF;
         else if (state == ST_EVAL)   last_tile <= tile;
         if (state == ST_RD)          wait_cnt <= '0;
         else if (state == ST_WAIT)   wait_cnt <= wait_cnt + 4'd1;
      end
   end

endmodule

// File: tb/tb_tunnel_carver.sv
// Directed bench for tunnel_carver with a behavioural 256x4 RAM (1-cycle read).
module tb_tunnel_carver;

   logic       clk100m = 1'b0;
   logic       rst_n;
   logic       level_start;
   logic [9:0] dig_posx, dig_posy;
   logic [3:0] vgaram_douta;
   logic       vgaram_we;
   logic [7:0] vgaram_addra;
   logic [3:0] vgaram_dina;
   logic       score_inc;
   logic       busy;

   logic       pre_en = 1'b0;
   logic [7:0] pre_addr = 8'd0;
   logic [3:0] pre_data = 4'd0;
   logic [3:0] mem [256] = '{default: 4'd0};

   int n_tests = 0;
   int n_fail  = 0;

   // results of the last watch() window
   int   n_wr, n_sc, sc_bad;
   int   wr_addr, wr_din;
   logic saw_rd;

   always #5 clk100m = ~clk100m;

   tunnel_carver dut (
      .clk100m      (clk100m),
      .rst_n        (rst_n),
      .level_start  (level_start),
      .dig_posx     (dig_posx),
      .dig_posy     (dig_posy),
      .vgaram_douta (vgaram_douta),
      .vgaram_we    (vgaram_we),
      .vgaram_addra (vgaram_addra),
      .vgaram_dina  (vgaram_dina),
      .score_inc    (score_inc),
      .busy         (busy)
   );

   // RAM model: read-first, one cycle read latency, bench-side preload port.
   always @(posedge clk100m) begin
      if (pre_en)         mem[pre_addr] <= pre_data;
      else if (vgaram_we) mem[vgaram_addra] <= vgaram_dina;
      vgaram_douta <= mem[vgaram_addra];
   end

   task automatic check(input string tag, input int got, input int exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Expected initial level, written from the level description.
   function automatic int exp_fill(input int a);
      int r;
      r = a / 16;
      if (r == 0 || r >= 15) return 0;
      if (a % 8 == 5)        return 2;
      return 1;
   endfunction

   task automatic pulse_level();
      @(negedge clk100m) level_start = 1'b1;
      @(negedge clk100m) level_start = 1'b0;
   endtask

   task automatic move(input int x, input int y);
      @(negedge clk100m);
      dig_posx = 10'(x);
      dig_posy = 10'(y);
   endtask

   task automatic watch(input int n, input int rd_addr);
      n_wr = 0; n_sc = 0; sc_bad = 0; wr_addr = -1; wr_din = -1; saw_rd = 1'b0;
      repeat (n) begin
         @(negedge clk100m);
         if (vgaram_we) begin
            n_wr++;
            wr_addr = vgaram_addra;
            wr_din  = vgaram_dina;
         end
         if (score_inc) begin
            n_sc++;
            if (!vgaram_we) sc_bad++;
         end
         if (!vgaram_we && vgaram_addra == 8'(rd_addr)) saw_rd = 1'b1;
      end
   endtask

   // Follows a fill started by pulse_level: sequence, busy length and final RAM image.
   task automatic fill_check(input string tag);
      int waited = 0, errs = 0, busy_len = 0, ram_errs = 0, first_addr;
      while (!vgaram_we && waited < 20) begin
         @(negedge clk100m);
         waited++;
      end
      check({tag, "_we_seen"}, int'(vgaram_we), 1);
      first_addr = vgaram_addra;
      check({tag, "_first_addr"}, first_addr, 0);
      for (int i = 0; i < 256; i++) begin
         if (!vgaram_we || vgaram_addra != 8'(i) || int'(vgaram_dina) != exp_fill(i)) errs++;
         if (busy) busy_len++;
         @(negedge clk100m);
      end
      check({tag, "_seq_errs"}, errs, 0);
      check({tag, "_busy_len"}, busy_len, 256);
      check({tag, "_busy_end"}, int'(busy), 0);
      for (int i = 0; i < 256; i++)
         if (int'(mem[i]) != exp_fill(i)) ram_errs++;
      check({tag, "_ram_errs"}, ram_errs, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int idle_wait, z0, z1;
      rst_n       = 1'b0;
      level_start = 1'b0;
      dig_posx    = 10'd0;
      dig_posy    = 10'd0;
      repeat (3) @(negedge clk100m);
      check("rst_we",    int'(vgaram_we),    0);
      check("rst_addr",  int'(vgaram_addra), 0);
      check("rst_dina",  int'(vgaram_dina),  0);
      check("rst_score", int'(score_inc),    0);
      check("rst_busy",  int'(busy),         0);
      rst_n = 1'b1;
      repeat (30) @(negedge clk100m);

      // 1: initial fill
      pulse_level();
      fill_check("t1");
      z0 = 0; z1 = 0;
      for (int i = 0; i < 16; i++)    if (mem[i] != 4'd0) z0++;
      for (int i = 240; i < 256; i++) if (mem[i] != 4'd0) z1++;
      check("t1_row0_nonzero", z0, 0);
      check("t1_addr21", int'(mem[21]), 2);
      check("t1_addr22", int'(mem[22]), 1);
      check("t1_tail_nonzero", z1, 0);

      // 2: (0,0) -> (45,40) carves dirt at tile 17
      repeat (40) @(negedge clk100m);
      move(45, 40);
      watch(60, 300);
      check("t2_writes", n_wr, 1);
      check("t2_addr", wr_addr, 17);
      check("t2_dina", wr_din, 0);
      check("t2_score", n_sc, 0);
      check("t2_mem17", int'(mem[17]), 0);

      // 3: emerald at tile 37, then moves within / out of / back into it
      move(200, 80);
      watch(60, 300);
      check("t3_writes", n_wr, 1);
      check("t3_addr", wr_addr, 37);
      check("t3_dina", wr_din, 0);
      check("t3_score", n_sc, 1);
      check("t3_score_no_we", sc_bad, 0);
      move(210, 90);
      watch(60, 300);
      check("t3_same_writes", n_wr, 0);
      check("t3_same_score", n_sc, 0);
      move(240, 80);
      watch(60, 300);
      check("t3_t38_writes", n_wr, 1);
      check("t3_t38_addr", wr_addr, 38);
      check("t3_t38_score", n_sc, 0);
      move(200, 80);
      watch(60, 300);
      check("t3_back_writes", n_wr, 0);
      check("t3_back_score", n_sc, 0);

      // 4: off-field position clamps to tile 239 holding a bag
      @(negedge clk100m);
      pre_en = 1'b1; pre_addr = 8'd239; pre_data = 4'd3;
      @(negedge clk100m);
      pre_en = 1'b0;
      move(700, 590);
      watch(80, 239);
      check("t4_read_239", int'(saw_rd), 1);
      check("t4_writes", n_wr, 0);
      check("t4_score", n_sc, 0);
      check("t4_mem239", int'(mem[239]), 3);

      // 5: level_start during the divide of a carve to tile 171
      move(450, 400);
      idle_wait = 0;
      while (busy && idle_wait < 60) begin
         @(negedge clk100m);
         idle_wait++;
      end
      check("t5_idle_found", int'(busy), 0);
      repeat (3) @(negedge clk100m);
      check("t5_in_div_busy", int'(busy), 1);
      check("t5_in_div_we", int'(vgaram_we), 0);
      pulse_level();
      fill_check("t5");
      check("t5_mem171", int'(mem[171]), 1);
      watch(60, 300);
      check("t5_carve_after_addr", wr_addr, 171);
      check("t5_carve_after_writes", n_wr, 1);

      // 6: reset in the middle of a fill
      pulse_level();
      repeat (100) @(negedge clk100m);
      check("t6_midfill_busy", int'(busy), 1);
      rst_n = 1'b0;
      #1;
      check("t6_rst_we",    int'(vgaram_we), 0);
      check("t6_rst_busy",  int'(busy),      0);
      check("t6_rst_score", int'(score_inc), 0);
      @(negedge clk100m);
      rst_n = 1'b1;
      repeat (40) @(negedge clk100m);
      pulse_level();
      fill_check("t6");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
